// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: carries register-file and HI/LO write-back fields,
// inserts bubbles or holds from the stall vector, and parks multi-cycle accumulate state.
module ex_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int TEMP_W  = 64,
  parameter int CNT_W   = 2,
  parameter int SCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic              ex_whilo,
  input  logic [TEMP_W-1:0] hilo_temp_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              mem_whilo,
  output logic [TEMP_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [SCNT_W-1:0] stall_cycles
);

  logic s_here;
  logic s_down;

  assign s_here = stall[STAGE];

  // The last stage has nothing downstream, so a stall there always bubbles.
  generate
    if (STAGE + 1 < STALL_W) begin : g_down
      assign s_down = stall[STAGE+1];
    end else begin : g_no_down
      assign s_down = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_valid    <= 1'b0;
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      hilo_temp_o  <= '0;
      cnt_o        <= '0;
      stall_cycles <= '0;
    end else if (s_here) begin
      if (!s_down) begin
        // Bubble: downstream drains, execute's partial accumulate is parked here.
        mem_valid   <= 1'b0;
        mem_wd      <= '0;
        mem_wreg    <= 1'b0;
        mem_wdata   <= '0;
        mem_hi      <= '0;
        mem_lo      <= '0;
        mem_whilo   <= 1'b0;
        hilo_temp_o <= hilo_temp_i;
        cnt_o       <= cnt_i;
      end
      if (stall_cycles != {SCNT_W{1'b1}}) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end else begin
      mem_valid    <= ex_valid;
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_whilo    <= ex_whilo;
      hilo_temp_o  <= '0;
      cnt_o        <= '0;
      stall_cycles <= '0;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: three instances (default, 2-bit stall counter, last stage)
// share stimulus and are compared each cycle against a behavioural model.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] temp;
    logic [1:0]  cnt;
    logic [7:0]  scnt;
  } st_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;

  st_t o_main, o_sat, o_bnd;
  st_t e_main, e_sat, e_bnd;
  logic [7:0] scnt_main, scnt_bnd;
  logic [1:0] scnt_sat;

  int n_checks = 0;
  int n_pass   = 0;

  ex_mem_pipe u_main (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_valid(o_main.valid), .mem_wd(o_main.wd), .mem_wreg(o_main.wreg),
    .mem_wdata(o_main.wdata), .mem_hi(o_main.hi), .mem_lo(o_main.lo),
    .mem_whilo(o_main.whilo), .hilo_temp_o(o_main.temp), .cnt_o(o_main.cnt),
    .stall_cycles(scnt_main)
  );

  ex_mem_pipe #(.SCNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_valid(o_sat.valid), .mem_wd(o_sat.wd), .mem_wreg(o_sat.wreg),
    .mem_wdata(o_sat.wdata), .mem_hi(o_sat.hi), .mem_lo(o_sat.lo),
    .mem_whilo(o_sat.whilo), .hilo_temp_o(o_sat.temp), .cnt_o(o_sat.cnt),
    .stall_cycles(scnt_sat)
  );

  ex_mem_pipe #(.STAGE(5)) u_bnd (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_valid(o_bnd.valid), .mem_wd(o_bnd.wd), .mem_wreg(o_bnd.wreg),
    .mem_wdata(o_bnd.wdata), .mem_hi(o_bnd.hi), .mem_lo(o_bnd.lo),
    .mem_whilo(o_bnd.whilo), .hilo_temp_o(o_bnd.temp), .cnt_o(o_bnd.cnt),
    .stall_cycles(scnt_bnd)
  );

  assign o_main.scnt = scnt_main;
  assign o_sat.scnt  = {6'd0, scnt_sat};
  assign o_bnd.scnt  = scnt_bnd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: what the stage should hold after one clock, given the
  // stall bits seen from position `stage` (bits above the vector read as 0).
  function automatic st_t model_step(st_t cur, int stage, int smax);
    st_t nx;
    int  sv, here, down, next_cnt;
    nx   = cur;
    sv   = int'(stall);
    here = (sv >> stage) & 1;
    down = (sv >> (stage + 1)) & 1;
    next_cnt = (int'(cur.scnt) + 1 > smax) ? smax : int'(cur.scnt) + 1;
    if (rst || flush) begin
      nx = '0;
    end else if (here == 1 && down == 0) begin
      nx       = '0;
      nx.temp  = hilo_temp_i;
      nx.cnt   = cnt_i;
      nx.scnt  = 8'(next_cnt);
    end else if (here == 1) begin
      nx.scnt  = 8'(next_cnt);
    end else begin
      nx = '{valid: ex_valid, wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi,
             lo: ex_lo, whilo: ex_whilo, temp: 64'd0, cnt: 2'd0, scnt: 8'd0};
    end
    return nx;
  endfunction

  // scoreboard compare of one instance
  task automatic compare(input string name, input st_t o, input st_t e);
    check({name, ".valid"}, 64'(o.valid), 64'(e.valid));
    check({name, ".wd"},    64'(o.wd),    64'(e.wd));
    check({name, ".wreg"},  64'(o.wreg),  64'(e.wreg));
    check({name, ".wdata"}, 64'(o.wdata), 64'(e.wdata));
    check({name, ".hi"},    64'(o.hi),    64'(e.hi));
    check({name, ".lo"},    64'(o.lo),    64'(e.lo));
    check({name, ".whilo"}, 64'(o.whilo), 64'(e.whilo));
    check({name, ".temp"},  o.temp,       e.temp);
    check({name, ".cnt"},   64'(o.cnt),   64'(e.cnt));
    check({name, ".scnt"},  64'(o.scnt),  64'(e.scnt));
  endtask

  task automatic step();
    @(posedge clk);
    e_main = model_step(e_main, 3, 255);
    e_sat  = model_step(e_sat, 3, 3);
    e_bnd  = model_step(e_bnd, 5, 255);
    #1;
    compare("main", o_main, e_main);
    compare("sat",  o_sat,  e_sat);
    compare("bnd",  o_bnd,  e_bnd);
  endtask

  // driver tasks
  task automatic drive_ex(input logic v, input logic [4:0] wd, input logic wr,
                          input logic [31:0] wdata);
    ex_valid = v;
    ex_wd    = wd;
    ex_wreg  = wr;
    ex_wdata = wdata;
    ex_hi    = $urandom;
    ex_lo    = $urandom;
    ex_whilo = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_random();
    drive_ex(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), $urandom);
    hilo_temp_i = {$urandom, $urandom};
    cnt_i       = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 6))
      0, 1: stall = 6'b000000;
      2:    stall = 6'b001000;
      3:    stall = 6'b011000;
      4:    stall = 6'b100000;
      5:    stall = 6'b110000;
      default: stall = 6'($urandom);
    endcase
    flush = ($urandom_range(0, 19) == 0);
    rst   = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    e_main = '0; e_sat = '0; e_bnd = '0;
    rst = 1'b1; flush = 1'b0; stall = '0;
    hilo_temp_i = 64'hFFFF_0000_1234_5678; cnt_i = 2'd3;
    drive_ex(1'b1, 5'd17, 1'b1, 32'h1234_5678);

    // reset with busy inputs
    repeat (2) step();
    check("rst.valid", 64'(o_main.valid), 64'd0);
    check("rst.wdata", 64'(o_main.wdata), 64'd0);
    check("rst.scnt",  64'(o_main.scnt),  64'd0);

    // first load after reset
    rst = 1'b0;
    drive_ex(1'b1, 5'd5, 1'b1, 32'hDEADBEEF);
    step();
    check("load.wd",    64'(o_main.wd),    64'd5);
    check("load.wdata", 64'(o_main.wdata), 64'hDEADBEEF);
    check("load.valid", 64'(o_main.valid), 64'd1);

    // hold: downstream also stalled
    stall = 6'b011000;
    for (int i = 1; i <= 3; i++) begin
      drive_ex(1'b1, 5'(i + 10), 1'b0, $urandom);
      step();
      check("hold.wdata", 64'(o_main.wdata), 64'hDEADBEEF);
      check("hold.scnt",  64'(o_main.scnt),  64'(i));
    end
    stall = 6'b000000;
    drive_ex(1'b0, 5'd9, 1'b1, 32'hCAFE_F00D);
    step();
    check("release.wdata", 64'(o_main.wdata), 64'hCAFE_F00D);
    check("release.valid", 64'(o_main.valid), 64'd0);
    check("release.scnt",  64'(o_main.scnt),  64'd0);

    // bubble parks the accumulate state
    stall = 6'b001000; hilo_temp_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    step();
    check("bub.valid", 64'(o_main.valid), 64'd0);
    check("bub.wreg",  64'(o_main.wreg),  64'd0);
    check("bub.wdata", 64'(o_main.wdata), 64'd0);
    check("bub.temp",  o_main.temp,       64'h0000_0001_0000_0002);
    check("bub.cnt",   64'(o_main.cnt),   64'd1);
    stall = 6'b000000;
    step();
    check("adv.temp", o_main.temp,     64'd0);
    check("adv.cnt",  64'(o_main.cnt), 64'd0);

    // flush beats a hold while accumulate state is parked
    stall = 6'b001000; cnt_i = 2'd1; step();
    stall = 6'b011000; step();
    check("pre_flush.cnt", 64'(o_main.cnt), 64'd1);
    flush = 1'b1; step();
    flush = 1'b0;
    check("flush.cnt",   64'(o_main.cnt),  64'd0);
    check("flush.temp",  o_main.temp,      64'd0);
    check("flush.scnt",  64'(o_main.scnt), 64'd0);
    check("flush.valid", 64'(o_main.valid), 64'd0);

    // saturation on the 2-bit counter
    stall = 6'b011000;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("sat.scnt", 64'(o_sat.scnt), 64'((i > 3) ? 3 : i));
    end

    // last stage: its own stall alone is a bubble
    stall = 6'b000000; drive_ex(1'b1, 5'd3, 1'b1, 32'h0BAD_F00D); step();
    stall = 6'b100000; hilo_temp_i = 64'hA5A5_0000_5A5A_FFFF; cnt_i = 2'd2;
    step();
    check("bnd.valid", 64'(o_bnd.valid), 64'd0);
    check("bnd.temp",  o_bnd.temp,       64'hA5A5_0000_5A5A_FFFF);
    check("bnd.cnt",   64'(o_bnd.cnt),   64'd2);
    check("bnd.scnt",  64'(o_bnd.scnt),  64'd1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX/MEM pipeline register. It carries the register-file write-back fields and the HI/LO write-back fields from execute to memory access, with a valid bit. It decides per cycle from the global stall vector whether to advance, hold or insert a bubble, and accepts a flush (exception) input. On bubble cycles it latches multi-cycle accumulate state (madd/msub intermediate and step count) and feeds it back to execute, and it counts consecutive stall cycles for performance monitoring.

Parameters:
DATA_W, 32, width of wdata/hi/lo
ADDR_W, 5, register-file address width
STALL_W, 6, width of global stall vector
STAGE, 3, index of this register's stall bit; downstream bit is STAGE+1
TEMP_W, 64, width of multi-cycle accumulate temp
CNT_W, 2, width of multi-cycle step counter
SCNT_W, 8, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  STALL_W  global stall vector, bit=1 means stop
flush  in  1  discard the stage contents (exception/redirect)
ex_valid  in  1  execute stage holds a real instruction
ex_wd  in  ADDR_W  destination register
ex_wreg  in  1  register write enable
ex_wdata  in  DATA_W  write data
ex_hi, ex_lo  in  DATA_W each  HI/LO values
ex_whilo  in  1  HI/LO write enable
hilo_temp_i  in  TEMP_W  accumulate intermediate from execute
cnt_i  in  CNT_W  accumulate step from execute
mem_valid  out  1  registered valid
mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo  out  as inputs  registered fields
hilo_temp_o  out  TEMP_W  accumulate intermediate fed back to execute
cnt_o  out  CNT_W  accumulate step fed back to execute
stall_cycles  out  SCNT_W  consecutive stalled cycles, saturating

Behaviour:
- All outputs are registered. They update on the rising clk edge only. Latency is 1 cycle.
- Let s_here = stall[STAGE] and s_down = stall[STAGE+1]. If STAGE+1 >= STALL_W, s_down is a constant 0.
- Per-cycle priority: rst > flush > BUBBLE > HOLD > ADVANCE.
- rst=1: every output is set to 0. This covers mem_valid=0, mem_wd=0 (NOP address), the write enables, data, hi/lo, hilo_temp_o, cnt_o and stall_cycles.
- flush=1 (and rst=0): same as reset for all outputs, including hilo_temp_o, cnt_o and stall_cycles. Flush overrides any stall combination.
- BUBBLE (s_here=1, s_down=0):
  - mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo and mem_whilo are set to 0.
  - hilo_temp_o <= hilo_temp_i and cnt_o <= cnt_i.
  - stall_cycles increments.
- HOLD (s_here=1, s_down=1):
  - All mem_* outputs, hilo_temp_o and cnt_o keep their values.
  - stall_cycles increments.
- ADVANCE (s_here=0):
  - Each mem_* output takes its ex_* input, and mem_valid <= ex_valid.
  - hilo_temp_o and cnt_o are set to 0.
  - stall_cycles is set to 0.
  - s_down is ignored in this case.
- stall_cycles saturates at 2^SCNT_W-1 and does not wrap.
- Validity does not gate the write fields. With ex_valid=0 on ADVANCE, the fields are still captured verbatim; downstream uses the write enables.
- Reset or flush in the middle of a multi-cycle accumulate discards hilo_temp_o/cnt_o. Execute restarts the instruction.
- No combinational path from any input to any output.

Test Plan:
1. Reset: drive rst=1 with non-zero ex_* inputs for 2 cycles -> all outputs 0. Release rst with stall=0, ex_wd=5, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_valid=1 -> after 1 edge, mem_wd=5, mem_wdata=DEADBEEF, mem_valid=1.
2. Hold: load the values from scenario 1, then stall=6'b011000 for 3 cycles with changing ex_* -> mem_* unchanged at DEADBEEF, stall_cycles=1,2,3. Then stall=0 -> the new ex_* are captured and stall_cycles=0.
3. Bubble with accumulate: stall=6'b001000, hilo_temp_i=64'h0000_0001_0000_0002, cnt_i=1 -> mem_valid=0, mem_wreg=0, mem_wdata=0, hilo_temp_o=64'h0000_0001_0000_0002, cnt_o=1. Next cycle stall=0 -> hilo_temp_o=0, cnt_o=0.
4. Flush priority: set stall=6'b011000 and flush=1 while holding valid data with cnt_o=1 -> all outputs 0 after 1 edge, including stall_cycles and cnt_o.
5. Saturation: SCNT_W=2, hold stall for 6 cycles -> stall_cycles sequence 1,2,3,3,3,3.
6. Boundary stage: STAGE=5, STALL_W=6, stall=6'b100000 -> treated as BUBBLE (mem_valid=0, temp captured), not HOLD.
